// File: rtl/stream_diff_pkg.sv
// Shared types and constants for the stream differencer.
// The STREAM_DIFF_SAT_EN build option uses the saturation limits defined here.
package stream_diff_pkg;

    localparam int DEFAULT_BITS = 16;

    typedef enum logic [0:0] {
        HIST_EMPTY  = 1'b0,
        HIST_PRIMED = 1'b1
    } hist_state_e;

    // Largest positive two's complement value of a given width.
    function automatic logic signed [63:0] sat_max(input int bits);
        return (64'sd1 <<< (bits - 1)) - 64'sd1;
    endfunction

    // Most negative two's complement value of a given width.
    function automatic logic signed [63:0] sat_min(input int bits);
        return -(64'sd1 <<< (bits - 1));
    endfunction

endpackage

// File: rtl/stream_diff_sub_core.sv
// Combinational BITS-wide subtractor with signed overflow detection.
// Overflowed results are clamped when STREAM_DIFF_SAT_EN is defined; otherwise they wrap.
module sub_core
    import stream_diff_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic [BITS-1:0] minuend,
    input  logic [BITS-1:0] subtrahend,
    output logic [BITS-1:0] result,
    output logic            ovf
);

`ifdef STREAM_DIFF_SAT_EN
    localparam logic signed [63:0] MAX_WIDE = sat_max(BITS);
    localparam logic signed [63:0] MIN_WIDE = sat_min(BITS);
    localparam logic [BITS-1:0]    SAT_MAX  = MAX_WIDE[BITS-1:0];
    localparam logic [BITS-1:0]    SAT_MIN  = MIN_WIDE[BITS-1:0];
`endif

    logic [BITS-1:0] wrap_s;

    // Wrapped difference, overflow flag and optional clamp.
    always_comb begin
        wrap_s = minuend - subtrahend;
        ovf    = (minuend[BITS-1] != subtrahend[BITS-1]) &&
                 (wrap_s[BITS-1] != minuend[BITS-1]);
`ifdef STREAM_DIFF_SAT_EN
        if (ovf) begin
            // A negative minuend can only overflow downwards.
            if (minuend[BITS-1]) begin
                result = SAT_MIN;
            end else begin
                result = SAT_MAX;
            end
        end else begin
            result = wrap_s;
        end
`else
        result = wrap_s;
`endif
    end

endmodule

// File: rtl/stream_differencer.sv
// First-difference filter y[n] = x[n] - x[n-1] with a two-stage valid/ready pipeline.
// Define STREAM_DIFF_SAT_EN to saturate overflowed results instead of wrapping them.
module stream_differencer
    import stream_diff_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_first,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_ovf
);

    hist_state_e     state_r;
    hist_state_e     state_nxt_s;
    logic            s1_valid_r;
    logic [BITS-1:0] s1_cur_r;
    logic [BITS-1:0] s1_prev_r;
    logic [BITS-1:0] hist_r;
    logic [BITS-1:0] prev_sel_s;
    logic [BITS-1:0] diff_s;
    logic            ovf_s;
    logic            accept_s;
    logic            advance_s;

    assign advance_s = s1_valid_r && (!out_valid || out_ready);
    assign in_ready  = !s1_valid_r || advance_s;
    assign accept_s  = in_valid && in_ready;

    // History FSM next state and selection of the x[n-1] operand.
    always_comb begin
        state_nxt_s = state_r;
        prev_sel_s  = hist_r;
        case (state_r)
            HIST_EMPTY: begin
                prev_sel_s = {BITS{1'b0}};
                if (accept_s) begin
                    state_nxt_s = HIST_PRIMED;
                end else begin
                    state_nxt_s = HIST_EMPTY;
                end
            end
            HIST_PRIMED: begin
                state_nxt_s = HIST_PRIMED;
                if (in_first) begin
                    prev_sel_s = {BITS{1'b0}};
                end else begin
                    prev_sel_s = hist_r;
                end
            end
            default: begin
                state_nxt_s = HIST_EMPTY;
                prev_sel_s  = {BITS{1'b0}};
            end
        endcase
    end

    // History FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HIST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage 1: capture operands and update the history register on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_cur_r   <= {BITS{1'b0}};
            s1_prev_r  <= {BITS{1'b0}};
            hist_r     <= {BITS{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_cur_r   <= in_data;
            s1_prev_r  <= prev_sel_s;
            hist_r     <= in_data;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    sub_core #(
        .BITS(BITS)
    ) u_sub_core (
        .minuend   (s1_cur_r),
        .subtrahend(s1_prev_r),
        .result    (diff_s),
        .ovf       (ovf_s)
    );

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {BITS{1'b0}};
            out_ovf   <= 1'b0;
        end else if (advance_s) begin
            out_valid <= 1'b1;
            out_data  <= diff_s;
            out_ovf   <= ovf_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_differencer.sv
// Self-checking bench for stream_differencer: directed table, corner sequences, random scoreboard.
module tb_stream_differencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_first = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   model_prev = 0;
    bit   model_primed = 1'b0;

    typedef struct {
        logic         do_rst;
        logic [W-1:0] x;
        logic         first;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_sat;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[14];

    stream_differencer #(.BITS(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Reference: difference of plain integers, overflow when outside the signed range.
    task automatic model_push(input logic [W-1:0] x, input logic first);
        int   xs;
        int   p;
        int   d;
        exp_t e;
        xs = $signed(x);
        p  = (!model_primed || first) ? 0 : model_prev;
        d  = xs - p;
        e.ovf = (d > 32767) || (d < -32768);
`ifdef STREAM_DIFF_SAT_EN
        if (d > 32767) e.data = 16'h7FFF;
        else if (d < -32768) e.data = 16'h8000;
        else e.data = d[W-1:0];
`else
        e.data = d[W-1:0];
`endif
        model_prev   = xs;
        model_primed = 1'b1;
        exp_q.push_back(e);
    endtask

    // Scoreboard: observe handshakes away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_primed = 1'b0;
                model_prev   = 0;
            end else begin
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        fail_now("sb_spurious_output");
                    end else begin
                        chk("sb_data", {16'h0, out_data}, {16'h0, exp_q[0].data});
                        chk("sb_ovf", {31'h0, out_ovf}, {31'h0, exp_q[0].ovf});
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready === 1'b1) model_push(in_data, in_first);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_out_ovf", {31'h0, out_ovf}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic send_one(input string name, input logic [W-1:0] x, input logic first,
                            input logic [W-1:0] exp_d, input logic exp_o);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = x; in_first = first; out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_out_valid"}, {31'h0, out_valid}, 32'h1);
        chk({name, "_out_data"}, {16'h0, out_data}, {16'h0, exp_d});
        chk({name, "_out_ovf"}, {31'h0, out_ovf}, {31'h0, exp_o});
    endtask

    initial begin
        logic [W-1:0] exp_d;
        logic [W-1:0] strm[3];
        logic [W-1:0] strm_exp[3];
        logic [W-1:0] bp_x[4];
        logic [W-1:0] bp_exp[4];
        int sent;
        int got;

        vecs[0]  = '{1'b1, 16'h0005, 1'b1, 16'h0005, 16'h0005, 1'b0};
        vecs[1]  = '{1'b0, 16'h0008, 1'b0, 16'h0003, 16'h0003, 1'b0};
        vecs[2]  = '{1'b0, 16'h0003, 1'b0, 16'hFFFB, 16'hFFFB, 1'b0};
        vecs[3]  = '{1'b0, 16'h7FFF, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[4]  = '{1'b0, 16'h8000, 1'b0, 16'h0001, 16'h8000, 1'b1};
        vecs[5]  = '{1'b0, 16'h000A, 1'b1, 16'h000A, 16'h000A, 1'b0};
        vecs[6]  = '{1'b0, 16'h0014, 1'b1, 16'h0014, 16'h0014, 1'b0};
        vecs[7]  = '{1'b0, 16'h8000, 1'b1, 16'h8000, 16'h8000, 1'b0};
        vecs[8]  = '{1'b0, 16'h7FFF, 1'b0, 16'hFFFF, 16'h7FFF, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h8001, 16'h8001, 1'b0};
        vecs[10] = '{1'b0, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[11] = '{1'b0, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1};
        vecs[12] = '{1'b1, 16'h1234, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vecs[13] = '{1'b0, 16'h1000, 1'b0, 16'hFDCC, 16'hFDCC, 1'b0};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_rst) do_reset();
`ifdef STREAM_DIFF_SAT_EN
            exp_d = vecs[i].exp_sat;
`else
            exp_d = vecs[i].exp_wrap;
`endif
            send_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].first, exp_d, vecs[i].exp_ovf);
        end

        // Back-to-back stream: results on consecutive cycles.
        do_reset();
        strm[0] = 16'h0005; strm[1] = 16'h0008; strm[2] = 16'h0003;
        strm_exp[0] = 16'h0005; strm_exp[1] = 16'h0003; strm_exp[2] = 16'hFFFB;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin
                in_valid = 1'b1; in_data = strm[k]; in_first = (k == 0);
            end else begin
                in_valid = 1'b0; in_first = 1'b0;
            end
            @(negedge clk);
            if (k >= 2) begin
                chk($sformatf("stream_valid%0d", k - 2), {31'h0, out_valid}, 32'h1);
                chk($sformatf("stream_data%0d", k - 2), {16'h0, out_data}, {16'h0, strm_exp[k - 2]});
            end
        end

        // Backpressure: six stalled cycles, then release and collect all four results.
        do_reset();
        bp_x[0] = 16'h000A; bp_x[1] = 16'h001E; bp_x[2] = 16'h0019; bp_x[3] = 16'h0064;
        bp_exp[0] = 16'h000A; bp_exp[1] = 16'h0014; bp_exp[2] = 16'hFFFB; bp_exp[3] = 16'h004B;
        sent = 0;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid = 1'b1; in_data = bp_x[sent]; in_first = (sent == 0);
            @(negedge clk);
            if (out_valid) chk("bp_stall_data", {16'h0, out_data}, {16'h0, bp_exp[0]});
            if (in_ready) sent++;
        end
        chk("bp_accepted", sent, 32'd2);
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (sent < 4) begin
                in_valid = 1'b1; in_data = bp_x[sent]; in_first = (sent == 0);
            end else begin
                in_valid = 1'b0; in_first = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                chk($sformatf("bp_out%0d", got), {16'h0, out_data}, {16'h0, bp_exp[got]});
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_results_seen", got, 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset with two samples in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h0064; in_first = 1'b1;
        @(posedge clk); #1;
        in_data = 16'h00C8; in_first = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        send_one("midrst_next", 16'h0003, 1'b0, 16'h0003, 1'b0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: in_data = 16'h7FFF;
                1: in_data = 16'h8000;
                default: in_data = 16'($urandom);
            endcase
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
